// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous dmem,
// with bounded lock bursts and read-data return routed to the issuing requester.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned   CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_t;

  owner_t             r_owner;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rd_pend;
  logic               r_rd_id;

  logic               w_hold_id;
  logic               w_hold_lock;
  logic               w_other_req;
  logic               w_hold;
  logic               w_req;
  logic               w_id;
  logic               w_gnt;
  logic               w_we;
  logic               w_lock;
  owner_t             w_own;

  // Winner selection: a lock holder keeps the memory unless its burst is spent
  // and the other side is waiting; otherwise plain round-robin on r_last.
  always_comb begin
    w_hold_id   = (r_owner == OWN_1);
    w_hold_lock = w_hold_id ? r1_lock : r0_lock;
    w_other_req = w_hold_id ? r0_req : r1_req;
    w_hold      = (r_owner != OWN_NONE) && w_hold_lock &&
                  !((r_cnt == CNT_MAX) && w_other_req);
    w_id  = 1'b0;
    w_req = 1'b0;
    if (w_hold) begin
      w_id  = w_hold_id;
      w_req = w_hold_id ? r1_req : r0_req;
    end else if (r0_req && r1_req) begin
      w_id  = ~r_last;
      w_req = 1'b1;
    end else begin
      w_id  = r1_req;
      w_req = r0_req | r1_req;
    end
    w_gnt  = w_req & reset;
    w_we   = w_id ? r1_we : r0_we;
    w_lock = w_id ? r1_lock : r0_lock;
    w_own  = w_id ? OWN_1 : OWN_0;
  end

  assign r0_gnt      = w_gnt & ~w_id;
  assign r1_gnt      = w_gnt & w_id;
  assign mem_address = (w_gnt && w_id) ? r1_addr : r0_addr;
  assign mem_data    = (w_gnt && w_id) ? r1_wdata : r0_wdata;
  assign mem_wren    = w_gnt & w_we;

  assign r0_rvalid = r_rd_pend & ~r_rd_id;
  assign r1_rvalid = r_rd_pend & r_rd_id;
  assign r0_rdata  = mem_q;
  assign r1_rdata  = mem_q;

  // Ownership, burst count, round-robin pointer and read-return pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner   <= OWN_NONE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt & ~w_we;
      r_rd_id   <= w_id;
      if (w_gnt) begin
        r_last <= w_id;
        if (w_lock) begin
          if (r_owner != w_own) begin
            r_owner <= w_own;
            r_cnt   <= CNT_W'(1);
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_owner <= OWN_NONE;
          r_cnt   <= '0;
        end
      end else if ((r_owner != OWN_NONE) && !w_hold_lock) begin
        r_owner <= OWN_NONE;
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port synchronous data memory (dmem) between the processor and a second master, such as a debug/loader or DMA engine. It issues at most one memory access per cycle and applies round-robin priority. A requester may lock the memory for bounded bursts. Read data is routed back to the requester that issued the read. The arbiter sits between the requesters and the dmem instance, with its memory-side ports taking over the existing address/data/wren/q connections.

## Interface
Parameters:
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- MAX_BURST, 8, maximum locked beats before a lock holder must yield to a waiting requester (≥1)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- rN_req  in  1  requester N (N=0 processor, N=1 auxiliary) access request
- rN_we  in  1  1 = write, 0 = read
- rN_lock  in  1  request to keep ownership for consecutive beats
- rN_addr  in  ADDR_W  word address
- rN_wdata  in  DATA_W  write data
- rN_gnt  out  1  access accepted this cycle
- rN_rvalid  out  1  read data valid for requester N
- rN_rdata  out  DATA_W  read data (the mem_q value)
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  from dmem; valid one cycle after a read address is applied

## Operation
- Registered state:
  - owner ∈ {NONE, OWN0, OWN1}
  - last, the requester granted most recently
  - beat counter cnt, ceil(log2(MAX_BURST+1)) bits
  - rd_pend and rd_id, the read-return pipeline
- The winner w is combinational each cycle:
  - **Locked case:** owner=OWNx, rx_lock=1, and not (cnt==MAX_BURST and other req=1). Then w=x if rx_req=1; otherwise there is no grant and the memory idles. The other requester stalls.
  - **Otherwise:** if exactly one requester asserts req, it wins. If both assert req, the requester ≠ last wins.
- Only rw_gnt is asserted. The memory outputs carry the winner's signals: mem_address=rw_addr, mem_data=rw_wdata, mem_wren=rw_we.
- With no grant: mem_wren=0, and mem_address/mem_data hold the r0 values (don't-care).
- Updates on the rising edge when a grant occurs:
  - last ← w
  - If rw_lock=1 and owner≠OWNw: owner ← OWNw, cnt ← 1.
  - If rw_lock=1 and owner=OWNw: cnt ← min(cnt+1, MAX_BURST).
  - If rw_lock=0: owner ← NONE, cnt ← 0.
- Updates on the rising edge with no grant: if owner=OWNx and rx_lock=0, then owner ← NONE and cnt ← 0.
- **Forced yield:** when the locked case fails because cnt==MAX_BURST and the other requester is waiting, round-robin applies. Since last=x, the other requester wins. owner then follows the rules above.
- **Read return:** rd_pend ← gnt & ~we and rd_id ← w on each edge. In the following cycle, r{rd_id}_rvalid=rd_pend and both rN_rdata=mem_q. Reads are never reordered or dropped except by reset.
- Writes produce no response; gnt is the only completion indication.

## Timing
- Reset values:
  - owner=NONE, last=1 (requester 0 wins the first tie), cnt=0, rd_pend=0
  - While reset is low: all rN_gnt=0, all rN_rvalid=0, mem_wren=0
- **Grant latency:** 0 cycles. gnt is combinational from req/state. The requester must hold req/we/addr/wdata stable until it samples gnt=1, then may change them on the next edge.
- **Read latency:** rvalid is high exactly 1 cycle after the gnt cycle, for 1 cycle.
- **Throughput:** 1 access per cycle. Back-to-back read, write and read-after-write are legal. A read issued in the cycle after a write to the same address returns the new data.
- **Fairness:**
  - Both requesters asserting continuously without lock alternate every cycle.
  - A locked requester holds the memory for at most MAX_BURST beats while the other waits, then loses at least 1 beat.
- **Simultaneous events:** req from the lock holder with lock dropping in the same cycle is arbitrated round-robin.
- **Reset mid-operation:** a pending rvalid is discarded, and any lock and in-flight grant are cancelled asynchronously.

## Test plan
- **Single-requester read:** reset high; r0 writes 0xDEADBEEF to addr 5, then reads addr 5 → r0_gnt=1 in both cycles; r0_rvalid=1 one cycle after the read with r0_rdata=0xDEADBEEF; r1_rvalid stays 0.
- **Contention:** r0 and r1 both request reads continuously from reset → grants alternate 0,1,0,1…; each rvalid lands on its own requester with the correct data.
- **Lock and forced yield:** MAX_BURST=8; r1 asserts lock+req with 12 writes while r0 requests → r1 gets 8 consecutive grants, then r0 gets 1, then r1 resumes.
- **Lock release:** r1 locks for 3 beats, then drops lock while r0 waits → r0 is granted in the cycle lock drops; owner=NONE.
- **Lock-holder idle:** r1 holds lock with req=0 for 2 cycles while r0 requests → no grants and mem_wren=0 for 2 cycles; r0 is granted when r1 drops lock.
- **Async reset:** reset pulled low in the cycle after a read grant → rvalid never asserts, mem_wren=0 immediately; after release, a tie goes to r0.
